// File: rtl/joypad_responder.sv
// joypad_responder: digital joypad slave answering host polls on the att/clk/cmd serial bus
module joypad_responder #(
  parameter int ACK_DELAY = 100,
  parameter int ACK_WIDTH = 66
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        joy_att,
  input  logic        joy_clk,
  input  logic        joy_cmd,
  input  logic [15:0] buttons,
  output logic        joy_data,
  output logic        joy_ack,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        busy
);
  localparam int CW = $clog2(ACK_DELAY + ACK_WIDTH + 2);
  localparam logic [CW-1:0] ACK_LO = CW'(ACK_DELAY + 1);
  localparam logic [CW-1:0] ACK_HI = CW'(ACK_DELAY + ACK_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, IGNORE} state_t;
  state_t state, state_nxt;
  logic [2:0] att_q, clk_q;
  logic [1:0] cmd_q;
  logic att_s, att_fall, clk_rise, clk_fall, cmd_s;
  logic [7:0] tx_shift, rx_shift, rx_nxt, resp_nxt;
  logic [2:0] bit_cnt, byte_idx;
  logic [15:0] btn_q;
  logic last_bit, bad_byte, ack_start;
  logic [CW-1:0] ack_cnt, ack_cnt_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      att_q <= 3'b111;
      clk_q <= 3'b111;
      cmd_q <= 2'b11;
    end else begin
      att_q <= {att_q[1:0], joy_att};
      clk_q <= {clk_q[1:0], joy_clk};
      cmd_q <= {cmd_q[0], joy_cmd};
    end
  assign att_s = att_q[1];
  assign att_fall = ~att_q[1] & att_q[2];
  assign clk_rise = clk_q[1] & ~clk_q[2];
  assign clk_fall = ~clk_q[1] & clk_q[2];
  assign cmd_s = cmd_q[1];
  assign rx_nxt = {cmd_s, rx_shift[7:1]};
  assign last_bit = state == SHIFT && !att_s && clk_rise && bit_cnt == 3'd7;
  assign bad_byte = (byte_idx == 3'd0 && rx_nxt != 8'h01) || (byte_idx == 3'd1 && rx_nxt != 8'h42);
  assign ack_start = last_bit && !bad_byte && byte_idx <= 3'd3;
  assign resp_nxt = byte_idx == 3'd0 ? 8'h41 :
                    byte_idx == 3'd1 ? 8'h5A :
                    byte_idx == 3'd2 ? ~btn_q[7:0] :
                    byte_idx == 3'd3 ? ~btn_q[15:8] : 8'hFF;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = att_s ? IDLE :
                (state == IDLE && att_fall) ? SHIFT :
                (last_bit && (bad_byte || byte_idx == 3'd4)) ? IGNORE : state;
    ack_cnt_nxt = (att_s || state_nxt == IGNORE) ? '0 :
                  ack_cnt != '0 ? (ack_cnt == ACK_HI ? '0 : ack_cnt + CW'(1)) :
                  ack_start ? CW'(1) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      joy_data <= 1'b1;
      rx_byte <= 8'h00;
      rx_valid <= 1'b0;
      tx_shift <= 8'hFF;
      rx_shift <= 8'h00;
      bit_cnt <= 3'd0;
      byte_idx <= 3'd0;
      btn_q <= 16'h0000;
    end else begin
      rx_valid <= 1'b0;
      if (att_s) begin
        joy_data <= 1'b1;
        bit_cnt <= 3'd0;
        byte_idx <= 3'd0;
      end else if (state == IDLE) begin
        if (att_fall) begin
          joy_data <= 1'b1;
          bit_cnt <= 3'd0;
          byte_idx <= 3'd0;
          btn_q <= buttons;
          tx_shift <= 8'hFF;
        end
      end else if (state == IGNORE) begin
        joy_data <= 1'b1;
      end else begin
        if (clk_fall) begin
          joy_data <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[7:1]};
        end
        if (clk_rise) begin
          rx_shift <= rx_nxt;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (last_bit) begin
          rx_byte <= rx_nxt;
          rx_valid <= 1'b1;
          byte_idx <= byte_idx + 3'd1;
          tx_shift <= resp_nxt;
          if (state_nxt == IGNORE) joy_data <= 1'b1;
        end
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack_cnt <= '0;
      joy_ack <= 1'b1;
    end else begin
      ack_cnt <= ack_cnt_nxt;
      joy_ack <= !(ack_cnt_nxt >= ACK_LO && ack_cnt_nxt <= ACK_HI);
    end
endmodule

// File: tb/tb_joypad_responder.sv
// tb_joypad_responder: randomized poll traffic against a byte-level reference model
module tb_joypad_responder;
  localparam int ACK_DELAY = 100;
  localparam int ACK_WIDTH = 66;
  localparam int H = 8;
  localparam int GAP = 60;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic joy_att = 1'b1;
  logic joy_clk = 1'b1;
  logic joy_cmd = 1'b1;
  logic [15:0] buttons = 16'h0000;
  logic joy_data, joy_ack, rx_valid, busy;
  logic [7:0] rx_byte;
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int n_rv = 0;
  int n_ackf = 0;
  int last_rv = 0;
  int fall_c = 0;
  logic ack_prev = 1'b1;
  int ack_dly[256];
  int ack_wid[256];
  logic [7:0] cmd_q[5];
  logic [7:0] got_q[5];
  logic [7:0] exp_rx = 8'h00;

  joypad_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
    .clk(clk), .rst(rst), .joy_att(joy_att), .joy_clk(joy_clk), .joy_cmd(joy_cmd),
    .buttons(buttons), .joy_data(joy_data), .joy_ack(joy_ack), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      n_rv++;
      last_rv = cyc;
    end
    if (ack_prev && !joy_ack) begin
      if (n_ackf < 256) begin
        ack_dly[n_ackf] = cyc - last_rv;
        ack_wid[n_ackf] = -1;
      end
      fall_c = cyc;
      n_ackf++;
    end
    if (!ack_prev && joy_ack && n_ackf > 0 && n_ackf <= 256) ack_wid[n_ackf-1] = cyc - fall_c;
    ack_prev = joy_ack;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_byte(input logic [7:0] c, input int nbits, output logic [7:0] g);
    g = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      joy_clk = 1'b0;
      joy_cmd = c[i];
      repeat (H) @(negedge clk);
      g[i] = joy_data;
      joy_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    joy_cmd = 1'b1;
  endtask

  task automatic run_poll(input logic [15:0] btn, input logic chg, input logic [15:0] btn2);
    int rv0, ak0, erv, eack;
    bit ign;
    logic [7:0] tbl[5];
    logic [7:0] g;
    rv0 = n_rv;
    ak0 = n_ackf;
    erv = 0;
    eack = 0;
    ign = 1'b0;
    tbl = '{8'hFF, 8'h41, 8'h5A, ~btn[7:0], ~btn[15:8]};
    buttons = btn;
    @(negedge clk);
    joy_att = 1'b0;
    repeat (10) @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      if (chg && b == 2) buttons = btn2;
      host_byte(cmd_q[b], 8, g);
      got_q[b] = g;
      repeat (GAP) @(negedge clk);
    end
    repeat (200) @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("resp%0d", b), got_q[b], ign ? 8'hFF : tbl[b]);
      if (!ign) begin
        erv++;
        exp_rx = cmd_q[b];
        if ((b == 0 && cmd_q[b] != 8'h01) || (b == 1 && cmd_q[b] != 8'h42) || b == 4) ign = 1'b1;
        else eack++;
      end
    end
    chk("rx_valid_count", n_rv - rv0, erv);
    chk("ack_count", n_ackf - ak0, eack);
    for (int k = ak0; k < n_ackf && k < 256; k++) begin
      chk("ack_delay", ack_dly[k], ACK_DELAY);
      chk("ack_width", ack_wid[k], ACK_WIDTH);
    end
    chk("rx_byte", rx_byte, exp_rx);
    chk("busy_hold", busy, 1);
    joy_att = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_release", busy, 0);
    chk("data_idle", joy_data, 1);
  endtask

  initial begin
    logic [7:0] g;
    int tgt, m;
    repeat (3) @(negedge clk);
    chk("rst_data", joy_data, 1);
    chk("rst_ack", joy_ack, 1);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rv", n_rv, 0);

    cmd_q = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    run_poll(16'h0009, 1'b0, 16'h0000);
    cmd_q = '{8'h81, 8'h42, 8'h00, 8'h00, 8'h00};
    run_poll(16'h1234, 1'b0, 16'h0000);
    cmd_q = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    run_poll(16'h0000, 1'b1, 16'hFFFF);

    for (int t = 0; t < 8; t++) begin
      m = $urandom_range(0, 3);
      cmd_q[0] = 8'h01;
      cmd_q[1] = 8'h42;
      for (int i = 2; i < 5; i++) cmd_q[i] = 8'($urandom);
      if (m == 0) begin
        cmd_q[0] = 8'($urandom);
        if (cmd_q[0] == 8'h01) cmd_q[0] = 8'h81;
      end
      if (m == 1) begin
        cmd_q[1] = 8'($urandom);
        if (cmd_q[1] == 8'h42) cmd_q[1] = 8'h43;
      end
      run_poll(16'($urandom), 1'($urandom), 16'($urandom));
    end

    joy_att = 1'b0;
    repeat (10) @(negedge clk);
    host_byte(8'h01, 8, g);
    chk("ab_b0", g, 8'hFF);
    repeat (GAP) @(negedge clk);
    host_byte(8'h42, 8, g);
    chk("ab_b1", g, 8'h41);
    repeat (GAP) @(negedge clk);
    host_byte(8'h00, 4, g);
    chk("ab_b2_part", g, 8'hFA);
    joy_att = 1'b1;
    repeat (3) @(negedge clk);
    chk("ab_busy", busy, 0);
    chk("ab_data", joy_data, 1);
    exp_rx = 8'h42;
    chk("ab_rx_byte", rx_byte, exp_rx);
    cmd_q = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    run_poll(16'h5A3C, 1'b0, 16'h0000);

    joy_att = 1'b0;
    repeat (10) @(negedge clk);
    host_byte(8'h01, 8, g);
    repeat (GAP) @(negedge clk);
    host_byte(8'h42, 8, g);
    tgt = last_rv + ACK_DELAY + 5;
    for (int i = 0; i < 400 && cyc < tgt; i++) @(negedge clk);
    chk("ack_low", joy_ack, 0);
    joy_att = 1'b1;
    repeat (3) @(negedge clk);
    chk("ack_abort", joy_ack, 1);
    chk("ack_abort_busy", busy, 0);
    exp_rx = 8'h42;

    buttons = 16'h00FF;
    @(negedge clk);
    joy_att = 1'b0;
    repeat (10) @(negedge clk);
    host_byte(8'h01, 8, g);
    repeat (GAP) @(negedge clk);
    host_byte(8'h42, 8, g);
    repeat (GAP) @(negedge clk);
    host_byte(8'h00, 8, g);
    repeat (GAP) @(negedge clk);
    host_byte(8'h00, 3, g);
    chk("pre_rst_data", joy_data, 0);
    chk("pre_rst_busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_data", joy_data, 1);
    chk("arst_ack", joy_ack, 1);
    chk("arst_rx_byte", rx_byte, 0);
    chk("arst_rx_valid", rx_valid, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    joy_att = 1'b1;
    joy_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_rx = 8'h00;
    repeat (5) @(negedge clk);
    chk("rel_busy", busy, 0);
    cmd_q = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    run_poll(16'h8001, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/joypad_responder.md
JOYPAD_RESPONDER -- requirements
Module: joypad_responder

Interface
REQ-001 Parameter: ACK_DELAY, 100, clk cycles from 8th joy_clk rising edge to joy_ack assertion.
REQ-002 Parameter: ACK_WIDTH, 66, clk cycles joy_ack is held low.
REQ-003 clk  input  1  system clock (33 MHz domain).
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 joy_att  input  1  host select, active-low, asynchronous to clk.
REQ-006 joy_clk  input  1  host serial clock, idle high, asynchronous to clk.
REQ-007 joy_cmd  input  1  host-to-pad serial data, LSB first.
REQ-008 buttons  input  16  pressed buttons, active-high, bit 0 = SELECT ... bit 15 = SQUARE.
REQ-009 joy_data  output  1  pad-to-host serial data, LSB first, 1 when not driving.
REQ-010 joy_ack  output  1  byte acknowledge, active-low.
REQ-011 rx_byte  output  8  last complete byte received on joy_cmd.
REQ-012 rx_valid  output  1  one-clk pulse when rx_byte updates.
REQ-013 busy  output  1  high whenever state != IDLE.

Function
REQ-014 joy_att, joy_clk, joy_cmd SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized copies (3rd flop); all actions occur on the clk edge of detection.
REQ-015 States SHALL be IDLE, SHIFT, IGNORE.
REQ-016 IDLE -> SHIFT on synchronized joy_att falling edge; byte index := 0, bit count := 0, buttons latched, tx shift register := 0xFF.
REQ-017 In SHIFT, each joy_clk falling edge SHALL drive joy_data := tx_shift[0] and shift tx right by one.
REQ-018 In SHIFT, each joy_clk rising edge SHALL shift synchronized joy_cmd into rx_shift MSB (LSB-first), bit count += 1.
REQ-019 On 8th rising edge: rx_byte := assembled byte, rx_valid pulses, bit count := 0, byte index += 1, tx shift loaded with next response byte.
REQ-020 Response sequence by byte index: 0 -> 0xFF, 1 -> 0x41, 2 -> 0x5A, 3 -> ~latched_buttons[7:0], 4 -> ~latched_buttons[15:8].
REQ-021 Byte 0 received != 0x01, or byte 1 received != 0x42 -> IGNORE, no ack for that byte, joy_data := 1.
REQ-022 After byte indices 0-3 complete successfully, ack timer SHALL start; joy_ack low exactly ACK_WIDTH cycles beginning ACK_DELAY cycles after the 8th rising-edge detection.
REQ-023 No ack SHALL be issued after byte 4; after byte 4, state -> IGNORE.
REQ-024 joy_clk edges during an ack window SHALL be processed normally; the ack timer is independent and SHALL not be restarted until it finishes.
REQ-025 IGNORE SHALL hold joy_data = 1, joy_ack = 1, ignore joy_clk, and wait for joy_att high.
REQ-026 Synchronized joy_att high in any state SHALL force IDLE next cycle, joy_data := 1, joy_ack := 1, ack timer cleared, counters cleared (abort mid-byte or mid-ack).
REQ-027 joy_att falling and joy_clk edge detected in same cycle: att handled first, clock edge ignored.
REQ-028 Changes on buttons during a transaction SHALL not affect response bytes 3-4.

Reset
REQ-029 On rst: state IDLE, joy_data = 1, joy_ack = 1, rx_byte = 0x00, rx_valid = 0, busy = 0, synchronizers set to 1 (idle level), ack timer cleared.
REQ-030 Deassertion of rst SHALL not generate any edge detection on joy_att or joy_clk.

Verification
REQ-031 Full poll: att low, host sends 01,42,00,00,00 with buttons = 0x0009 -> host samples FF,41,5A,F6,FF; 4 ack pulses each ACK_WIDTH cycles wide; rx_valid pulses 5 times; no ack after 5th byte.
REQ-032 Wrong address: first cmd byte 0x81 -> response FF, rx_byte = 0x81, no ack, joy_data stays 1 for remaining clocks, busy until att high.
REQ-033 Abort: att high after 4 bits of byte 2 -> IDLE within 3 clk, joy_data = 1; next transaction starts cleanly with 0xFF response.
REQ-034 Abort during ack: att high at cycle ACK_DELAY+5 after byte 1 -> joy_ack returns high within 3 clk.
REQ-035 Button latch: buttons change 0x0000 -> 0xFFFF after byte 1 -> bytes 3,4 read FF,FF.
REQ-036 Async rst asserted mid-byte-3 -> outputs at reset values immediately, busy = 0.
